// File: rtl/baton_pkg.sv
// Shared types and defaults for the baton beat tracker.
//   dir_t            : direction state, also the dir_out encoding
//   DEF_COORD_WIDTH  : default coordinate width
//   DEF_PERIOD_WIDTH : default gap/period counter width
package baton_pkg;

  typedef enum logic [1:0] {
    DIR_UNKNOWN = 2'b00,
    DIR_INC     = 2'b01,
    DIR_DEC     = 2'b10
  } dir_t;

  localparam int DEF_COORD_WIDTH  = 11;
  localparam int DEF_PERIOD_WIDTH = 24;

endpackage

// File: rtl/baton_ema_filter.sv
// Exponential moving average on the coordinate stream:
//   q <= q + ((d - q) >>> SHIFT), with the first sample after reset loaded directly.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   vld_in   : d_in is valid this cycle
//   d_in     : unsigned sample
//   vld_out  : vld_in delayed one cycle; q_out holds the filtered value then
//   q_out    : filtered sample
module baton_ema_filter #(
  parameter int WIDTH = 11,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] q_out
);

  logic                    seen_q;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   step;
  logic        [WIDTH:0]   sum;
  logic                    ema_unused;

  // Signed difference with floor-rounding shift; q + step stays within [0, 2^WIDTH),
  // so the carry bit of sum is never needed.
  assign diff       = $signed({1'b0, d_in}) - $signed({1'b0, q_out});
  assign step       = diff >>> SHIFT;
  assign sum        = {1'b0, q_out} + $unsigned(step);
  assign ema_unused = sum[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q  <= 1'b0;
      vld_out <= 1'b0;
      q_out   <= '0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) begin
        seen_q <= 1'b1;
        q_out  <= seen_q ? sum[WIDTH-1:0] : d_in;
      end
    end
  end

endmodule

// File: rtl/baton_beat_tracker.sv
// Baton stroke-reversal tracker: hysteresis + refractory reversal detection on the
// camera centre-of-mass coordinate, beat/peak classification and beat period measure.
// Ports:
//   clk_camera_in    : only clock
//   rst_in           : synchronous active-high reset
//   y_com_in         : unsigned coordinate, valid when measure_in=1
//   measure_in       : sample strobe
//   change_out       : pulse on any accepted reversal
//   beat_out         : pulse on INC->DEC reversal (coordinate maximum)
//   peak_out         : pulse on DEC->INC reversal (coordinate minimum)
//   dir_out          : 00 unknown, 01 increasing, 10 decreasing
//   beat_period_out  : cycles between the last two beats (all-ones when saturated)
//   period_valid_out : two beats seen since reset
// Build option: BATON_SMOOTH_EN inserts an EMA filter ahead of the tracker
// (adds one cycle of latency).
module baton_beat_tracker
  import baton_pkg::*;
#(
  parameter int COORD_WIDTH  = DEF_COORD_WIDTH,
  parameter int HYST         = 4,
  parameter int MIN_GAP      = 200000,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                    clk_camera_in,
  input  logic                    rst_in,
  input  logic [COORD_WIDTH-1:0]  y_com_in,
  input  logic                    measure_in,
  output logic                    change_out,
  output logic                    beat_out,
  output logic                    peak_out,
  output logic [1:0]              dir_out,
  output logic [PERIOD_WIDTH-1:0] beat_period_out,
  output logic                    period_valid_out
);

  localparam logic [PERIOD_WIDTH-1:0]       CNT_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0]       GAP_MIN = PERIOD_WIDTH'(MIN_GAP);
  localparam logic signed [COORD_WIDTH:0]   HYST_S  = (COORD_WIDTH+1)'(HYST);

  logic [COORD_WIDTH-1:0] trk_y;
  logic                   trk_vld;

`ifdef BATON_SMOOTH_EN
  baton_ema_filter #(
    .WIDTH (COORD_WIDTH),
    .SHIFT (SMOOTH_SHIFT)
  ) u_ema (
    .clk     (clk_camera_in),
    .rst     (rst_in),
    .vld_in  (measure_in),
    .d_in    (y_com_in),
    .vld_out (trk_vld),
    .q_out   (trk_y)
  );
`else
  logic smooth_unused;
  assign smooth_unused = |SMOOTH_SHIFT;
  assign trk_y         = y_com_in;
  assign trk_vld       = measure_in;
`endif

  dir_t                    dir_q, dir_nx;
  logic [COORD_WIDTH-1:0]  ext_q, ext_nx;
  logic                    seen_q, seen_nx;
  logic                    beat_nx, peak_nx;
  logic [PERIOD_WIDTH-1:0] gap_q, per_q, period_q, per_inc;
  logic                    beat_seen_q, pv_q;
  logic                    chg_q, beat_q, peak_q;
  logic signed [COORD_WIDTH:0] rise, fall;
  logic                    gap_ok;

  // Zero-extended signed differences: rise = y - ext, fall = ext - y.
  assign rise   = $signed({1'b0, trk_y}) - $signed({1'b0, ext_q});
  assign fall   = $signed({1'b0, ext_q}) - $signed({1'b0, trk_y});
  assign gap_ok = gap_q >= GAP_MIN;
  // The beat cycle itself is counted, so the period equals the beat pulse spacing.
  assign per_inc = (per_q == CNT_MAX) ? CNT_MAX : per_q + 1'b1;

  always_comb begin
    dir_nx  = dir_q;
    ext_nx  = ext_q;
    seen_nx = seen_q;
    beat_nx = 1'b0;
    peak_nx = 1'b0;
    if (trk_vld) begin
      if (!seen_q) begin
        seen_nx = 1'b1;
        ext_nx  = trk_y;
      end else begin
        case (dir_q)
          DIR_UNKNOWN: begin
            if (rise >= HYST_S) begin
              dir_nx = DIR_INC;
              ext_nx = trk_y;
            end else if (fall >= HYST_S) begin
              dir_nx = DIR_DEC;
              ext_nx = trk_y;
            end
          end
          DIR_INC: begin
            if (trk_y > ext_q) ext_nx = trk_y;
            // A retreat inside the refractory window is ignored; ext is kept so a
            // later sample can still qualify.
            else if (fall >= HYST_S && gap_ok) begin
              dir_nx  = DIR_DEC;
              ext_nx  = trk_y;
              beat_nx = 1'b1;
            end
          end
          DIR_DEC: begin
            if (trk_y < ext_q) ext_nx = trk_y;
            else if (rise >= HYST_S && gap_ok) begin
              dir_nx  = DIR_INC;
              ext_nx  = trk_y;
              peak_nx = 1'b1;
            end
          end
          default: dir_nx = DIR_UNKNOWN;
        endcase
      end
    end
  end

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      dir_q       <= DIR_UNKNOWN;
      ext_q       <= '0;
      seen_q      <= 1'b0;
      chg_q       <= 1'b0;
      beat_q      <= 1'b0;
      peak_q      <= 1'b0;
      gap_q       <= '0;
      per_q       <= '0;
      period_q    <= '0;
      beat_seen_q <= 1'b0;
      pv_q        <= 1'b0;
    end else begin
      dir_q  <= dir_nx;
      ext_q  <= ext_nx;
      seen_q <= seen_nx;
      chg_q  <= beat_nx | peak_nx;
      beat_q <= beat_nx;
      peak_q <= peak_nx;
      if (beat_nx | peak_nx)   gap_q <= '0;
      else if (gap_q != CNT_MAX) gap_q <= gap_q + 1'b1;
      if (beat_nx) begin
        per_q       <= '0;
        beat_seen_q <= 1'b1;
        if (beat_seen_q) begin
          period_q <= per_inc;
          pv_q     <= 1'b1;
        end
      end else if (per_q != CNT_MAX) begin
        per_q <= per_q + 1'b1;
      end
    end
  end

  assign change_out       = chg_q;
  assign beat_out         = beat_q;
  assign peak_out         = peak_q;
  assign dir_out          = dir_q;
  assign beat_period_out  = period_q;
  assign period_valid_out = pv_q;

endmodule

// File: tb/tb_baton_beat_tracker.sv
// Self-checking bench for baton_beat_tracker (HYST=4, MIN_GAP=10, PERIOD_WIDTH=8).
// Outputs are packed as {change, beat, peak, dir[1:0], period_valid, period[7:0]}.
module tb_baton_beat_tracker;

  localparam int CW = 11;
  localparam int PW = 8;
  localparam int NV = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m   = 1'b0;
  logic [CW-1:0] y   = '0;
  logic          chg, beat, peak, pv;
  logic [1:0]    dir;
  logic [PW-1:0] per;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  baton_beat_tracker #(
    .COORD_WIDTH  (CW),
    .HYST         (4),
    .MIN_GAP      (10),
    .PERIOD_WIDTH (PW),
    .SMOOTH_SHIFT (2)
  ) dut (
    .clk_camera_in    (clk),
    .rst_in           (rst),
    .y_com_in         (y),
    .measure_in       (m),
    .change_out       (chg),
    .beat_out         (beat),
    .peak_out         (peak),
    .dir_out          (dir),
    .beat_period_out  (per),
    .period_valid_out (pv)
  );

  typedef struct {
    logic [CW-1:0] y;
    logic          m;
    logic [13:0]   exp;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [13:0] outs();
    return {chg, beat, peak, dir, pv, per};
  endfunction

  function automatic logic [13:0] ex(input logic c, input logic b, input logic p,
                                     input logic [1:0] d, input logic v, input logic [7:0] pr);
    return {c, b, p, d, v, pr};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [CW-1:0] yv, input logic mv);
    @(negedge clk);
    rst = r; y = yv; m = mv;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc = 0;
    chk("reset", 0, 32'(outs()), 32'd0);
  endtask

  // Idle until the next step() lands on step number n.
  task automatic idle_to(input int n);
    while (cyc < n - 1) step(1'b0, '0, 1'b0);
  endtask

  task automatic setv(input int i, input logic [CW-1:0] yv, input logic mv, input logic [13:0] e);
    tbl[i].y = yv; tbl[i].m = mv; tbl[i].exp = e;
  endtask

`ifdef BATON_SMOOTH_EN
  int ef;
  initial begin
    do_reset();
    step(1'b0, 11'd100, 1'b1);
    chk("ema_load", 1, 32'(dut.u_ema.q_out), 32'd100);
    chk("ema_dir", 1, 32'(dir), 32'd0);
    step(1'b0, 11'd120, 1'b1);
    chk("ema_105", 2, 32'(dut.u_ema.q_out), 32'd105);
    chk("ema_dir", 2, 32'(dir), 32'd0);
    ef = 105;
    step(1'b0, 11'd120, 1'b1);
    ef = ef + ((120 - ef) >>> 2);
    chk("ema_dir2cyc", 3, 32'(dir), 32'd1);
    chk("ema_q", 3, 32'(dut.u_ema.q_out), 32'(ef));
    for (int k = 4; k <= 10; k++) begin
      step(1'b0, 11'd120, 1'b1);
      ef = ef + ((120 - ef) >>> 2);
      chk("ema_q", k, 32'(dut.u_ema.q_out), 32'(ef));
    end
    step(1'b0, 11'd0, 1'b1);
    ef = ef + ((0 - ef) >>> 2);
    chk("ema_q", 11, 32'(dut.u_ema.q_out), 32'(ef));
    chk("ema_beat_lat1", 11, 32'(beat), 32'd0);
    step(1'b0, 11'd0, 1'b0);
    chk("ema_beat_lat2", 12, 32'({beat, chg, dir}), 32'b1110);
    step(1'b0, 11'd0, 1'b0);
    chk("ema_beat_width", 13, 32'(beat), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
`else
  initial begin
    // Vector i is applied on clock edge i+1 after reset; gap seen there is i
    // (or cycles since the last accepted reversal minus one).
    setv(0,  11'd100, 1'b1, ex(0,0,0,2'b00,0,8'd0)); // first sample loads ext
    setv(1,  11'd101, 1'b1, ex(0,0,0,2'b00,0,8'd0));
    setv(2,  11'd102, 1'b1, ex(0,0,0,2'b00,0,8'd0));
    setv(3,  11'd103, 1'b1, ex(0,0,0,2'b00,0,8'd0)); // HYST-1: hold
    setv(4,  11'd104, 1'b1, ex(0,0,0,2'b01,0,8'd0)); // exactly HYST: INC
    setv(5,  11'd0,   1'b0, ex(0,0,0,2'b01,0,8'd0));
    setv(6,  11'd0,   1'b0, ex(0,0,0,2'b01,0,8'd0));
    setv(7,  11'd110, 1'b1, ex(0,0,0,2'b01,0,8'd0));
    setv(8,  11'd120, 1'b1, ex(0,0,0,2'b01,0,8'd0));
    setv(9,  11'd117, 1'b1, ex(0,0,0,2'b01,0,8'd0)); // retreat 3: no beat
    setv(10, 11'd116, 1'b1, ex(1,1,0,2'b10,0,8'd0)); // retreat 4, gap 10: beat
    setv(11, 11'd116, 1'b1, ex(0,0,0,2'b10,0,8'd0)); // strobe held: single pulse
    setv(12, 11'd110, 1'b1, ex(0,0,0,2'b10,0,8'd0)); // new minimum
    for (int i = 13; i <= 20; i++) setv(i, 11'd0, 1'b0, ex(0,0,0,2'b10,0,8'd0));
    setv(21, 11'd114, 1'b1, ex(1,0,1,2'b01,0,8'd0)); // rise 4, gap 10: peak
    setv(22, 11'd118, 1'b1, ex(0,0,0,2'b01,0,8'd0));
    for (int i = 23; i <= 27; i++) setv(i, 11'd0, 1'b0, ex(0,0,0,2'b01,0,8'd0));
    setv(28, 11'd114, 1'b1, ex(0,0,0,2'b01,0,8'd0)); // qualifies but gap 6: suppressed
    setv(29, 11'd115, 1'b1, ex(0,0,0,2'b01,0,8'd0));
    setv(30, 11'd0,   1'b0, ex(0,0,0,2'b01,0,8'd0));
    setv(31, 11'd0,   1'b0, ex(0,0,0,2'b01,0,8'd0));
    setv(32, 11'd114, 1'b1, ex(1,1,0,2'b10,1,8'd22)); // 2nd beat, 22 cycles after 1st
    setv(33, 11'd0,   1'b0, ex(0,0,0,2'b10,1,8'd22));

    do_reset();
    for (int i = 0; i < NV; i++) begin
      step(1'b0, tbl[i].y, tbl[i].m);
      chk("vec", i, 32'(outs()), 32'(tbl[i].exp));
    end

    // Beat period: beats at steps 12, 62, 126, 426.
    do_reset();
    step(1'b0, 11'd100, 1'b1);
    step(1'b0, 11'd110, 1'b1);
    chk("p_inc", 2, 32'(outs()), 32'(ex(0,0,0,2'b01,0,8'd0)));
    idle_to(12);  step(1'b0, 11'd100, 1'b1);
    chk("p_beat1", cyc, 32'(outs()), 32'(ex(1,1,0,2'b10,0,8'd0)));
    idle_to(32);  step(1'b0, 11'd110, 1'b1);
    chk("p_peak1", cyc, 32'(outs()), 32'(ex(1,0,1,2'b01,0,8'd0)));
    idle_to(62);  step(1'b0, 11'd100, 1'b1);
    chk("p_beat2", cyc, 32'(outs()), 32'(ex(1,1,0,2'b10,1,8'd50)));
    idle_to(82);  step(1'b0, 11'd110, 1'b1);
    chk("p_peak2", cyc, 32'(outs()), 32'(ex(1,0,1,2'b01,1,8'd50)));
    idle_to(126); step(1'b0, 11'd100, 1'b1);
    chk("p_beat3", cyc, 32'(outs()), 32'(ex(1,1,0,2'b10,1,8'd64)));
    idle_to(146); step(1'b0, 11'd110, 1'b1);
    idle_to(426); step(1'b0, 11'd100, 1'b1);
    chk("p_sat", cyc, 32'(outs()), 32'(ex(1,1,0,2'b10,1,8'd255)));

    // Reset colliding with a qualifying peak sample.
    idle_to(440);
    step(1'b1, 11'd110, 1'b1);
    chk("rst_win", cyc, 32'(outs()), 32'd0);
    step(1'b0, 11'd200, 1'b1);
    chk("rst_first", 1, 32'(outs()), 32'd0);
    step(1'b0, 11'd150, 1'b1);
    chk("rst_dec", 2, 32'(outs()), 32'(ex(0,0,0,2'b10,0,8'd0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
`endif

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
